// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline-stage definitions: default widths, control-bundle field
// offsets and the all-zero NOP control encoding.
package pipe_stage_reg_pkg;

  localparam int unsigned CTRL_W_DEF = 21;
  localparam int unsigned DATA_W_DEF = 20;
  localparam int unsigned CNT_W_DEF  = 16;

  // Control-bundle layout, LSB first
  localparam int unsigned CTRL_MUX2_OFS       = 0;
  localparam int unsigned CTRL_MUX3_OFS       = 1;
  localparam int unsigned CTRL_MUX4_OFS       = 2;
  localparam int unsigned CTRL_MUX5_OFS       = 3;
  localparam int unsigned CTRL_MUX6_OFS       = 4;
  localparam int unsigned CTRL_REG_BANK_OFS   = 5;   // 3 bits
  localparam int unsigned CTRL_DATA_MEM_OFS   = 8;   // 2 bits
  localparam int unsigned CTRL_COMPARATOR_OFS = 10;  // 3 bits
  localparam int unsigned CTRL_REG_FLAGS_OFS  = 13;  // 4 bits
  localparam int unsigned CTRL_ALU_OFS        = 17;  // 4 bits

  localparam logic [CTRL_W_DEF-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One pipeline entry: valid bit plus control bundle and data word.
// clear_ctrl invalidates and writes NOP control; data is left untouched.
module pipe_slot
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear_ctrl,
  input  logic [CTRL_W-1:0] ld_ctrl,
  input  logic [DATA_W-1:0] ld_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
  logic [DATA_W-1:0] data_q,  data_d;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clear_ctrl) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_W'(CTRL_NOP);
    end else if (load) begin
      valid_d = 1'b1;
      ctrl_d  = ld_ctrl;
      data_d  = ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign ctrl  = ctrl_q;
  assign data  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready, flush-to-bubble and a
// saturating stall counter. Define PIPE_SKID_EN for a registered-ready skid entry.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              up_xfer, main_load, main_clear;
  logic [CTRL_W-1:0] main_ld_ctrl;
  logic [DATA_W-1:0] main_ld_data;

`ifdef PIPE_SKID_EN
  logic              skid_valid, skid_load, skid_clear;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  // Main is always refilled from skid first, so skid_valid implies main_valid
  always_comb begin
    in_ready     = ~skid_valid;
    up_xfer      = in_valid & in_ready;
    main_ld_ctrl = in_ctrl;
    main_ld_data = in_data;
    if (skid_valid) begin
      main_load    = ~flush & out_ready;
      main_ld_ctrl = skid_ctrl;
      main_ld_data = skid_data;
    end else begin
      main_load    = ~flush & up_xfer & (~main_valid | out_ready);
    end
    main_clear = flush | (main_valid & out_ready & ~main_load);
    skid_load  = ~flush & up_xfer & main_valid & ~out_ready;
    skid_clear = flush | (skid_valid & out_ready);
  end

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (skid_load),
    .clear_ctrl (skid_clear),
    .ld_ctrl    (in_ctrl),
    .ld_data    (in_data),
    .valid      (skid_valid),
    .ctrl       (skid_ctrl),
    .data       (skid_data)
  );
`else
  always_comb begin
    in_ready     = ~main_valid | out_ready;
    up_xfer      = in_valid & in_ready;
    main_load    = ~flush & up_xfer;
    main_clear   = flush | (main_valid & out_ready & ~up_xfer);
    main_ld_ctrl = in_ctrl;
    main_ld_data = in_data;
  end
`endif

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk        (clk),
    .rst        (rst),
    .load       (main_load),
    .clear_ctrl (main_clear),
    .ld_ctrl    (main_ld_ctrl),
    .ld_data    (main_ld_data),
    .valid      (main_valid),
    .ctrl       (main_ctrl),
    .data       (main_data)
  );

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)
      cnt_d = '0;
    else if (main_valid && !out_ready && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign out_valid = main_valid;
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: fixed vector table, directed corner sequences and
// random traffic against a queue-based model of the stage.
module tb_pipe_stage_reg;
  localparam int CW = 21;
  localparam int DW = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, in_valid, out_ready, cnt_clr;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [CW-1:0] out_ctrl_a, out_ctrl_b;
  logic [DW-1:0] out_data_a, out_data_b;
  logic [15:0]   stall_cnt_a;
  logic [3:0]    stall_cnt_b;

  pipe_stage_reg u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_ctrl(out_ctrl_a), .out_data(out_data_a), .cnt_clr(cnt_clr), .stall_cnt(stall_cnt_a)
  );

  pipe_stage_reg #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_ctrl(out_ctrl_b), .out_data(out_data_b), .cnt_clr(cnt_clr), .stall_cnt(stall_cnt_b)
  );

  // Reference model: the stage is a FIFO of capacity 1 (or 2 with skid)
  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q[$];
  logic [DW-1:0] m_last = '0;
  int unsigned   m_cnt16 = 0, m_cnt4 = 0;
  int            checks = 0, errors = 0;

  function automatic bit m_ready();
`ifdef PIPE_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || out_ready;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit up, dn, stall;
    if (rst) begin
      q.delete();
      m_last  = '0;
      m_cnt16 = 0;
      m_cnt4  = 0;
      return;
    end
    up    = in_valid && m_ready();
    dn    = (q.size() > 0) && out_ready;
    stall = (q.size() > 0) && !out_ready;
    if (cnt_clr) begin
      m_cnt16 = 0;
      m_cnt4  = 0;
    end else if (stall) begin
      m_cnt16 = (m_cnt16 < 65535) ? m_cnt16 + 1 : 65535;
      m_cnt4  = (m_cnt4 < 15) ? m_cnt4 + 1 : 15;
    end
    if (flush) q.delete();
    else begin
      if (dn) void'(q.pop_front());
      if (up) q.push_back('{c: in_ctrl, d: in_data});
    end
    if (q.size() > 0) m_last = q[0].d;
  endtask

  task automatic check_outs();
    logic          ev;
    logic [CW-1:0] ec;
    logic [DW-1:0] ed;
    ev = q.size() > 0;
    ec = ev ? q[0].c : '0;
    ed = ev ? q[0].d : m_last;
    chk("out_valid", 32'(out_valid_a), 32'(ev));
    chk("out_ctrl",  32'(out_ctrl_a),  32'(ec));
    chk("out_data",  32'(out_data_a),  32'(ed));
    chk("stall_cnt", 32'(stall_cnt_a), m_cnt16);
    chk("out_valid_w4", 32'(out_valid_b), 32'(ev));
    chk("out_ctrl_w4",  32'(out_ctrl_b),  32'(ec));
    chk("out_data_w4",  32'(out_data_b),  32'(ed));
    chk("stall_cnt_w4", 32'(stall_cnt_b), m_cnt4);
  endtask

  // Called at a negedge: drive, check ready, advance model over the posedge
  task automatic apply(input bit r, input bit f, input bit iv, input bit ordy, input bit clr,
                       input logic [CW-1:0] c, input logic [DW-1:0] d);
    rst = r; flush = f; in_valid = iv; out_ready = ordy; cnt_clr = clr;
    in_ctrl = c; in_data = d;
    #1;
    if (!r) begin
      chk("in_ready",    32'(in_ready_a), 32'(m_ready()));
      chk("in_ready_w4", 32'(in_ready_b), 32'(m_ready()));
    end
    model_step();
    @(negedge clk);
    check_outs();
  endtask

  typedef struct {
    bit            r, f, iv, ordy, clr;
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    bit            ev;
    logic [CW-1:0] ec;
    logic [DW-1:0] ed;
    int unsigned   ecnt;
  } vec_t;

  vec_t tbl[11];

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    in_ctrl = '0; in_data = '0;

    //          r  f  iv or clr ctrl        data         ev ectrl       edata        cnt
    tbl[0]  = '{1, 0, 1, 0, 0, 21'h1FFFFF, 20'hABCDE, 0, 21'h000000, 20'h00000, 0};
    tbl[1]  = '{1, 0, 1, 0, 0, 21'h1FFFFF, 20'hABCDE, 0, 21'h000000, 20'h00000, 0};
    tbl[2]  = '{0, 0, 1, 1, 0, 21'h000123, 20'h11111, 1, 21'h000123, 20'h11111, 0};
    tbl[3]  = '{0, 0, 1, 1, 0, 21'h000456, 20'h22222, 1, 21'h000456, 20'h22222, 0};
    tbl[4]  = '{0, 0, 0, 1, 0, 21'h000000, 20'h00000, 0, 21'h000000, 20'h22222, 0};
    tbl[5]  = '{0, 0, 1, 0, 0, 21'h01ABCD, 20'h33333, 1, 21'h01ABCD, 20'h33333, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 21'h000000, 20'h00000, 1, 21'h01ABCD, 20'h33333, 1};
    tbl[7]  = '{0, 0, 0, 0, 0, 21'h000000, 20'h00000, 1, 21'h01ABCD, 20'h33333, 2};
    tbl[8]  = '{0, 0, 0, 0, 1, 21'h000000, 20'h00000, 1, 21'h01ABCD, 20'h33333, 0};
    tbl[9]  = '{0, 1, 1, 0, 0, 21'h00F0F0, 20'h44444, 0, 21'h000000, 20'h33333, 1};
    tbl[10] = '{0, 0, 0, 1, 0, 21'h000000, 20'h00000, 0, 21'h000000, 20'h33333, 1};

    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      apply(tbl[i].r, tbl[i].f, tbl[i].iv, tbl[i].ordy, tbl[i].clr, tbl[i].c, tbl[i].d);
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid_a), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_ctrl", i),  32'(out_ctrl_a),  32'(tbl[i].ec));
      chk($sformatf("tbl%0d_data", i),  32'(out_data_a),  32'(tbl[i].ed));
      chk($sformatf("tbl%0d_cnt", i),   32'(stall_cnt_a), tbl[i].ecnt);
      chk($sformatf("tbl%0d_cnt4", i),  32'(stall_cnt_b), tbl[i].ecnt);
    end

    // Streaming at full throughput
    for (int i = 1; i <= 16; i++) begin
      apply(0, 0, 1, 1, 0, CW'($urandom), DW'(i));
      chk("stream_data",  32'(out_data_a), i);
      chk("stream_valid", 32'(out_valid_a), 1);
    end

    // Five-cycle stall with upstream still pushing, then drain
    apply(0, 1, 0, 1, 1, '0, '0);
    apply(0, 0, 1, 1, 0, 21'h000055, 20'h00055);
    for (int i = 0; i < 5; i++) begin
      apply(0, 0, 1, 0, 0, CW'(21'h60 + i), DW'(20'h60 + i));
      chk("stall_hold", 32'(out_data_a), 32'h55);
    end
    chk("stall_cnt5", 32'(stall_cnt_a), 5);
    for (int i = 0; i < 3; i++) apply(0, 0, 0, 1, 0, '0, '0);
    chk("drained", 32'(out_valid_a), 0);

    // Saturation of the 4-bit counter, then clear during a stall
    apply(0, 1, 0, 1, 1, '0, '0);
    apply(0, 0, 1, 1, 0, 21'h000099, 20'h00099);
    for (int i = 0; i < 20; i++) apply(0, 0, 0, 0, 0, '0, '0);
    chk("sat_w4",  32'(stall_cnt_b), 15);
    chk("sat_w16", 32'(stall_cnt_a), 20);
    apply(0, 0, 0, 0, 1, '0, '0);
    chk("clr_w4",  32'(stall_cnt_b), 0);
    chk("clr_w16", 32'(stall_cnt_a), 0);
    apply(0, 0, 0, 0, 0, '0, '0);
    chk("after_clr", 32'(stall_cnt_a), 1);

    // Flush with a same-cycle upstream transfer into an empty stage
    apply(0, 1, 0, 1, 0, '0, '0);
    apply(0, 1, 1, 1, 0, 21'h1F00F, 20'h77777);
    chk("flush_valid", 32'(out_valid_a), 0);
    chk("flush_ctrl",  32'(out_ctrl_a),  0);
    apply(0, 0, 0, 1, 0, '0, '0);
    chk("flush_gone",  32'(out_valid_a), 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      apply($urandom_range(0, 99) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 31) == 0, CW'($urandom), DW'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
